// File: rtl/gyro_axi_regs.sv
// rtl/gyro_axi_regs.sv - AXI4-Lite register bank for gyro samples with coherent multi-axis snapshot
// Optional IRQ generation enabled by defining GYRO_AXI_REGS_IRQ_EN.
module gyro_axi_regs #(
  parameter int NUM_CH   = 3,
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
  output logic                         irq,
  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [31:0]                  S_AXI_WDATA,
  input  logic [3:0]                   S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [31:0]                  S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY
);

  localparam int NREG = 4 + NUM_CH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [SAMPLE_W-1:0] live   [NUM_CH];
  logic [SAMPLE_W-1:0] shadow [NUM_CH];
  logic                ctrl_en, ctrl_irq_en, st_new, st_ovr;
  logic [31:0]         count, scratch;
  logic                aw_rdy, ar_rdy, b_vld, r_vld;
  logic [1:0]          b_resp, r_resp;
  logic [31:0]         r_data, rd_mux;
  logic [31:0]         widx, ridx;
  logic                wr_accept, rd_accept, w_mapped, r_mapped;
  logic                wr_ctrl, wr_status, clr_cnt, capture, snap;
  logic                unused_addr_lsbs;

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = aw_rdy;
  assign S_AXI_BVALID  = b_vld;
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = r_vld;
  assign S_AXI_RRESP   = r_resp;
  assign S_AXI_RDATA   = r_data;

  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign widx      = 32'(S_AXI_AWADDR[ADDR_W-1:2]);
  assign ridx      = 32'(S_AXI_ARADDR[ADDR_W-1:2]);
  assign w_mapped  = widx < NREG;
  assign r_mapped  = ridx < NREG;
  assign wr_accept = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_accept = ar_rdy & S_AXI_ARVALID;
  assign wr_ctrl   = wr_accept & (widx == 32'd0) & S_AXI_WSTRB[0];
  assign wr_status = wr_accept & (widx == 32'd1) & S_AXI_WSTRB[0];
  assign clr_cnt   = wr_ctrl & S_AXI_WDATA[1];
  assign capture   = sample_valid & ctrl_en;
  // Reading CH0 freezes every axis so later CHk reads are coherent with it
  assign snap      = rd_accept & (ridx == 32'd4);

  function automatic logic [31:0] sext(input logic [SAMPLE_W-1:0] v);
    return 32'(signed'(v));
  endfunction

  always_comb begin
    rd_mux = '0;
    case (ridx)
      32'd0: rd_mux = {29'd0, ctrl_irq_en, 1'b0, ctrl_en};
      32'd1: rd_mux = {30'd0, st_ovr, st_new};
      32'd2: rd_mux = count;
      32'd3: rd_mux = scratch;
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (ridx == 32'(4 + k)) rd_mux = (k == 0) ? sext(live[k]) : sext(shadow[k]);
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_rdy  <= 1'b0;
      ar_rdy  <= 1'b0;
      b_vld   <= 1'b0;
      r_vld   <= 1'b0;
      b_resp  <= RESP_OKAY;
      r_resp  <= RESP_OKAY;
      r_data  <= '0;
      ctrl_en <= 1'b0;
      st_new  <= 1'b0;
      st_ovr  <= 1'b0;
      count   <= '0;
      scratch <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        live[k]   <= '0;
        shadow[k] <= '0;
      end
    end else begin
      aw_rdy <= S_AXI_AWVALID & S_AXI_WVALID & ~b_vld & ~aw_rdy;
      ar_rdy <= S_AXI_ARVALID & ~r_vld & ~ar_rdy;

      if (wr_accept) begin
        b_vld  <= 1'b1;
        b_resp <= w_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (b_vld & S_AXI_BREADY) begin
        b_vld <= 1'b0;
      end

      if (rd_accept) begin
        r_vld  <= 1'b1;
        r_resp <= r_mapped ? RESP_OKAY : RESP_SLVERR;
        r_data <= rd_mux;
      end else if (r_vld & S_AXI_RREADY) begin
        r_vld <= 1'b0;
      end

      if (wr_ctrl) ctrl_en <= S_AXI_WDATA[0];

      if (wr_accept && widx == 32'd3) begin
        for (int b = 0; b < 4; b++) begin
          if (S_AXI_WSTRB[b]) scratch[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end

      // Flag sets take priority over clears arriving in the same cycle
      st_new <= capture | (st_new & ~(snap | (wr_status & S_AXI_WDATA[0])));
      st_ovr <= (capture & st_new) | (st_ovr & ~(wr_status & S_AXI_WDATA[1]));

      if (clr_cnt)      count <= '0;
      else if (capture) count <= count + 32'd1;

      for (int k = 0; k < NUM_CH; k++) begin
        if (snap)    shadow[k] <= live[k];
        if (capture) live[k]   <= sample_data[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

`ifdef GYRO_AXI_REGS_IRQ_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_irq_en <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_irq_en <= S_AXI_WDATA[2];
      irq <= ctrl_irq_en & st_new;
    end
  end
`else
  assign ctrl_irq_en = 1'b0;
  assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_gyro_axi_regs.sv
// tb/tb_gyro_axi_regs.sv - self-checking bench for gyro_axi_regs against a register-level model
module tb_gyro_axi_regs;

  localparam int NUM_CH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [47:0] sample_data;
  logic        irq;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  bit        m_en, m_ien, m_new, m_ovr;
  bit [31:0] m_count, m_scratch;
  bit [15:0] m_live [NUM_CH];
  bit [15:0] m_shadow [NUM_CH];

  always #5 clk = ~clk;

  gyro_axi_regs dut (
    .ACLK(clk), .ARESET(rst), .sample_valid(sample_valid), .sample_data(sample_data), .irq(irq),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] sx(input bit [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic model_reset();
    m_en = 0; m_ien = 0; m_new = 0; m_ovr = 0; m_count = 0; m_scratch = 0;
    for (int k = 0; k < NUM_CH; k++) begin m_live[k] = 0; m_shadow[k] = 0; end
  endtask

  // A sample is judged against the state seen before this cycle's bus access
  task automatic model_sample(input bit fire, input bit ovr_set, input bit [47:0] sd, input bit clr);
    if (fire) begin
      if (ovr_set) m_ovr = 1;
      m_new = 1;
      for (int k = 0; k < NUM_CH; k++) m_live[k] = sd[16*k +: 16];
      m_count = m_count + 1;
    end
    if (clr) m_count = 0;
  endtask

  task automatic model_read(input int idx, input bit smp, input bit [47:0] sd,
                            output bit [31:0] d, output bit [1:0] r);
    bit fire, ovr_set;
    fire = smp & m_en; ovr_set = fire & m_new;
    d = 0; r = 0;
    if (idx == 0)      d = {29'd0, m_ien, 1'b0, m_en};
    else if (idx == 1) d = {30'd0, m_ovr, m_new};
    else if (idx == 2) d = m_count;
    else if (idx == 3) d = m_scratch;
    else if (idx == 4) begin
      d = sx(m_live[0]);
      for (int k = 0; k < NUM_CH; k++) m_shadow[k] = m_live[k];
      m_new = 0;
    end else if (idx < 4 + NUM_CH) d = sx(m_shadow[idx-4]);
    else r = 2'b10;
    model_sample(fire, ovr_set, sd, 0);
  endtask

  task automatic model_write(input int idx, input bit [31:0] d, input bit [3:0] s, input bit smp,
                             input bit [47:0] sd, output bit [1:0] r);
    bit fire, ovr_set, clr;
    fire = smp & m_en; ovr_set = fire & m_new; clr = 0; r = 0;
    if (idx == 0) begin
      if (s[0]) begin
        m_en = d[0]; clr = d[1];
`ifdef GYRO_AXI_REGS_IRQ_EN
        m_ien = d[2];
`endif
      end
    end else if (idx == 1) begin
      if (s[0] && d[0]) m_new = 0;
      if (s[0] && d[1]) m_ovr = 0;
    end else if (idx == 3) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
    end else if (idx >= 4 + NUM_CH) r = 2'b10;
    model_sample(fire, ovr_set, sd, clr);
  endtask

  task automatic do_read(input logic [7:0] a, input bit smp, input logic [47:0] sd, input int hold,
                         output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge clk); araddr = a; arvalid = 1; rready = (hold == 0);
    n = 0;
    while (!arready && n < 16) begin @(negedge clk); n++; end
    chk("arready_wait", arready, 1);
    if (smp) begin sample_valid = 1; sample_data = sd; end
    @(posedge clk); #1 arvalid = 0; sample_valid = 0;
    n = 0;
    while (!rvalid && n < 16) begin @(negedge clk); n++; end
    chk("rvalid_wait", rvalid, 1);
    d = rdata; r = rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, d);
      chk("rresp_hold", rresp, r);
    end
    rready = 1;
    @(posedge clk); #1 rready = 0;
    chk("rvalid_drop", rvalid, 0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input bit smp,
                          input logic [47:0] sd, input int hold, output logic [1:0] r);
    int n;
    @(negedge clk); awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = (hold == 0);
    n = 0;
    while (!awready && n < 16) begin @(negedge clk); n++; end
    chk("awready_wait", awready, 1);
    chk("wready_wait", wready, 1);
    if (smp) begin sample_valid = 1; sample_data = sd; end
    @(posedge clk); #1 awvalid = 0; wvalid = 0; sample_valid = 0;
    n = 0;
    while (!bvalid && n < 16) begin @(negedge clk); n++; end
    chk("bvalid_wait", bvalid, 1);
    r = bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, r);
    end
    bready = 1;
    @(posedge clk); #1 bready = 0;
    chk("bvalid_drop", bvalid, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input bit smp, input logic [47:0] sd,
                        input int hold, output logic [31:0] d);
    logic [1:0] r;
    bit [31:0]  ed;
    bit [1:0]   er;
    do_read(a, smp, sd, hold, d, r);
    model_read(int'(a >> 2), smp, sd, ed, er);
    chk({tag, "_rdata"}, d, ed);
    chk({tag, "_rresp"}, r, er);
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit smp, input logic [47:0] sd, input int hold);
    logic [1:0] r;
    bit [1:0]   er;
    do_write(a, d, s, smp, sd, hold, r);
    model_write(int'(a >> 2), d, s, smp, sd, er);
    chk({tag, "_bresp"}, r, er);
  endtask

  task automatic pulse(input logic [47:0] sd);
    @(negedge clk); sample_valid = 1; sample_data = sd;
    @(posedge clk); #1 sample_valid = 0;
    model_sample(m_en, m_en & m_new, sd, 0);
  endtask

  task automatic irq_chk(input string tag);
    @(posedge clk); #1;
`ifdef GYRO_AXI_REGS_IRQ_EN
    chk(tag, irq, m_ien & m_new);
`else
    chk(tag, irq, 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          op, idx;
    rst = 1; sample_valid = 0; sample_data = 0;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_bresp", bresp, 0);
    chk("rst_arready", arready, 0); chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);     chk("rst_rresp", rresp, 0);
    chk("rst_irq", irq, 0);
    rst = 0;

    for (int i = 0; i < 4; i++) rd_chk("rst_reg", 8'(4*i), 0, 0, 0, d);
    wr_chk("scratch_wr", 8'h0C, 32'hDEADBEEF, 4'b0011, 0, 0, 0);
    rd_chk("scratch_rd", 8'h0C, 0, 0, 0, d);
    chk("scratch_const", d, 32'h0000BEEF);

    wr_chk("ctrl_en", 8'h00, 32'h1, 4'hF, 0, 0, 0);
    pulse({16'h7FFF, 16'h0002, 16'h8001});
    rd_chk("ch0", 8'h10, 0, 0, 0, d); chk("ch0_const", d, 32'hFFFF8001);
    rd_chk("ch1", 8'h14, 0, 0, 0, d); chk("ch1_const", d, 32'h00000002);
    rd_chk("ch2", 8'h18, 0, 0, 0, d); chk("ch2_const", d, 32'h00007FFF);
    rd_chk("count1", 8'h08, 0, 0, 0, d); chk("count1_const", d, 32'h1);
    rd_chk("status_after_ch0", 8'h04, 0, 0, 0, d);

    rd_chk("snap_ch0", 8'h10, 0, 0, 0, d);
    pulse({16'h7FFF, 16'h1234, 16'h8001});
    rd_chk("snap_ch1_old", 8'h14, 0, 0, 0, d); chk("snap_old_const", d, 32'h2);
    rd_chk("snap_ch0b", 8'h10, 0, 0, 0, d);
    rd_chk("snap_ch1_new", 8'h14, 0, 0, 0, d); chk("snap_new_const", d, 32'h1234);

    pulse(48'h1); pulse(48'h2);
    rd_chk("status_3", 8'h04, 0, 0, 0, d); chk("status_3_const", d, 32'h3);
    wr_chk("w1c_ovr", 8'h04, 32'h2, 4'hF, 0, 0, 0);
    rd_chk("status_1", 8'h04, 0, 0, 0, d); chk("status_1_const", d, 32'h1);
    wr_chk("w1c_new", 8'h04, 32'h1, 4'hF, 0, 0, 0);
    rd_chk("status_0", 8'h04, 0, 0, 0, d); chk("status_0_const", d, 32'h0);

    rd_chk("unmapped_rd", 8'h40, 0, 0, 5, d);
    wr_chk("unmapped_wr", 8'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 5);
    wr_chk("ro_count_wr", 8'h08, 32'h55, 4'hF, 0, 0, 0);
    rd_chk("ro_count_rd", 8'h08, 0, 0, 0, d);

    wr_chk("ctrl_ien", 8'h00, 32'h5, 4'hF, 0, 0, 0);
    rd_chk("ctrl_rd", 8'h00, 0, 0, 0, d);
    pulse(48'h0000_0000_0042);
    chk("irq_not_yet", irq, 0);
    irq_chk("irq_rise");
    rd_chk("irq_ch0", 8'h10, 0, 0, 0, d);
    irq_chk("irq_fall");

    rd_chk("sim_ch0_smp", 8'h10, 1, 48'h0003_0002_0001, 0, d);
    rd_chk("sim_ch1_old", 8'h14, 0, 0, 0, d);
    rd_chk("sim_status", 8'h04, 0, 0, 0, d);
    wr_chk("sim_clr_cnt", 8'h00, 32'h3, 4'h1, 1, 48'h0006_0005_0004, 0);
    rd_chk("sim_count0", 8'h08, 0, 0, 0, d); chk("sim_count0_const", d, 32'h0);
    wr_chk("sim_w1c", 8'h04, 32'h3, 4'hF, 1, 48'h0009_0008_0007, 0);
    rd_chk("sim_status2", 8'h04, 0, 0, 0, d);
    irq_chk("sim_irq");

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        pulse({$urandom, $urandom});
      end else if (op == 1) begin
        idx = $urandom_range(0, 9);
        rd_chk("rnd_rd", 8'(4*idx + $urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
               {$urandom, $urandom}, $urandom_range(0, 2), d);
      end else begin
        idx = $urandom_range(0, 8);
        wdata = $urandom;
        if (idx == 0 && $urandom_range(0, 4) != 0) wdata[0] = 1'b1;
        wr_chk("rnd_wr", 8'(4*idx + $urandom_range(0, 3)), wdata, 4'($urandom),
               ($urandom_range(0, 3) == 0), {$urandom, $urandom}, $urandom_range(0, 2));
      end
      irq_chk("rnd_irq");
    end

    @(negedge clk); araddr = 8'h0C; arvalid = 1; rready = 0;
    repeat (4) @(negedge clk);
    arvalid = 0;
    chk("midrst_rvalid_pre", rvalid, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_irq", irq, 0);
    rst = 0;
    model_reset();
    rd_chk("post_rst_scratch", 8'h0C, 0, 0, 0, d);
    rd_chk("post_rst_count", 8'h08, 0, 0, 0, d);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gyro_axi_regs.md
Name: gyro_axi_regs

Overview:
- Parametrised AXI4-Lite slave register bank for gyro sensor data.
- Captures NUM_CH signed samples from the sensor front-end and counts samples; status flags are sticky.
- CPU reads are coherent across all axes: reading CH0 freezes a snapshot of every channel.
- Sits between the gyro SPI/front-end reader and the AXI interconnect. Successor to the fixed 4-register slave, generalised in channel count, sample width and address width.

Parameters:
- NUM_CH, 3, number of sample channels (1..16).
- SAMPLE_W, 16, width of each channel sample (8..32); sign-extended to 32 on readback.
- ADDR_W, 8, AXI address width; must cover 0x10 + 4*NUM_CH.

Ports:
- ACLK  in  1  single clock.
- ARESET  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle pulse; sample_data is valid this cycle.
- sample_data  in  NUM_CH*SAMPLE_W  channel k at bits [k*SAMPLE_W +: SAMPLE_W].
- irq  out  1  level interrupt (see Optional Feature).
- S_AXI_AWADDR in ADDR_W; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR in ADDR_W; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.

Behaviour:
- Clock and reset: one clock (ACLK); reset (ARESET) is synchronous and active-high.
- Reset values: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, irq 0. CTRL, STATUS, COUNT, SCRATCH, live and shadow sample registers all 0.
- Register map, decoded on addr[ADDR_W-1:2]:
  - 0x00 CTRL RW: bit0 EN; bit1 CLR_CNT, self-clearing, reads 0; bit2 IRQ_EN.
  - 0x04 STATUS, write-1-to-clear: bit0 NEW, bit1 OVR.
  - 0x08 COUNT RO: 32-bit sample count.
  - 0x0C SCRATCH RW.
  - 0x10+4k CHk RO, for k = 0..NUM_CH-1.
- Write channel:
  - AWREADY and WREADY assert together for one cycle when AWVALID & WVALID & !BVALID.
  - BVALID rises the cycle after acceptance and holds until BREADY.
  - WSTRB is honoured per byte on RW registers.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID & !RVALID.
  - RVALID and RDATA are registered the cycle after acceptance and held stable until RREADY.
- Responses: mapped address gives OKAY (2'b00). Unmapped address gives SLVERR (2'b10); the write has no effect and reads return 0. A write to an RO register gives OKAY and is ignored.
- Sample capture:
  - While EN=1, each sample_valid latches all channels into the live registers and increments COUNT (wraps 0xFFFFFFFF -> 0).
  - If NEW is already 1 on arrival, OVR sets.
  - NEW then sets.
  - While EN=0, sample_valid is ignored.
- Snapshot:
  - An accepted read of CH0 copies all live registers into shadow (CH0 data comes from live) and clears NEW.
  - Reads of CHk, k>0, return shadow.
- Simultaneous events:
  - sample_valid in the same cycle as a CH0 read accept: the snapshot takes the pre-update live values and NEW ends at 1 (set wins).
  - CLR_CNT in the same cycle as sample_valid: COUNT = 0 (clear wins).
  - STATUS W1C in the same cycle as a flag set: the flag ends at 1.
- Reset mid-transaction: the pending B/R response is dropped; the master must reissue.

Optional Feature:
- Macro GYRO_AXI_REGS_IRQ_EN.
- Defined: irq = IRQ_EN & NEW, registered (one cycle after NEW sets); it deasserts the cycle after NEW clears.
- Undefined: irq is tied to 0; CTRL bit2 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then read 0x00..0x0C -> all 0x00000000, RRESP OKAY; write SCRATCH 0xDEADBEEF with WSTRB 4'b0011, read back -> 0x0000BEEF.
- EN=1, pulse sample_valid with CH0=0x8001, CH1=0x0002, CH2=0x7FFF (SAMPLE_W=16) -> read 0x10/0x14/0x18 returns 0xFFFF8001/0x00000002/0x00007FFF; COUNT=1; NEW cleared after the CH0 read.
- Read CH0, then a sample with CH1=0x1234, then read CH1 -> returns the old snapshot value, not 0x1234; re-read CH0 then CH1 -> 0x00001234.
- Two samples without reading CH0 -> STATUS=0x3; write 0x2 to STATUS -> 0x1; write 0x1 -> 0x0.
- Read 0x40 and write 0x40 (unmapped, NUM_CH=3) -> RRESP/BRESP = 2'b10, RDATA 0; hold BREADY/RREADY low 5 cycles -> VALID and data held stable throughout.
- IRQ_EN=1 with the macro defined -> irq rises 1 cycle after the NEW set, falls after the CH0 read; with the macro undefined, irq stays 0.
